nco_sweep_ctrl: RTL

Sequencer that drives the frequency control word of the shared LUT-based NCO for modulation effects such as wah, vibrato and tremolo sweeps. It holds a configuration (range, step, rate, mode) and steps nco_freq between a minimum and a maximum at a programmable tick rate. It gates nco_en and reports progress to the effect-level control logic. It sits between the pedal control registers and the nco instance.

---
 rtl/nco_pkg.sv | 17 +
 rtl/nco_sweep_ctrl_tick_div.sv | 16 +
 rtl/nco_sweep_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/nco_pkg.sv
// nco_pkg: shared sweep-control types and default configuration for the NCO effects
package nco_pkg;
  localparam int FREQ_W = 8;
  localparam int DIV_W = 16;
  localparam int HOLD_W = 8;
  typedef enum logic [1:0] {UP_ONCE, DOWN_ONCE, TRIANGLE, SAW} sweep_mode_e;
  typedef enum logic [2:0] {S_IDLE, S_UP, S_DOWN, S_HOLD_TOP, S_HOLD_BOT} sweep_state_e;
  typedef struct packed {
    logic [FREQ_W-1:0] min;
    logic [FREQ_W-1:0] max;
    logic [FREQ_W-1:0] step;
    logic [DIV_W-1:0] div;
    sweep_mode_e mode;
    logic [HOLD_W-1:0] hold;
  } sweep_cfg_t;
  localparam sweep_cfg_t CFG_DEFAULT = '{min: '0, max: '1, step: FREQ_W'(1), div: '0, mode: UP_ONCE, hold: '0};
endpackage

// File: rtl/nco_sweep_ctrl_tick_div.sv
// tick_div: free-running prescaler that wraps after div+1 cycles, restartable via clr
module tick_div #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] div,
  output logic             wrap
);
  logic [WIDTH-1:0] count;
  // >= keeps the counter from running the full range if div shrinks under it
  assign wrap = count >= div;
  always_ff @(posedge clk)
    count <= (rst || clr || wrap) ? '0 : count + 1'b1;
endmodule

// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: steps the NCO frequency word between configured bounds at a prescaled tick rate
module nco_sweep_ctrl
  import nco_pkg::*;
#(
  parameter int FREQ_WIDTH = FREQ_W,
  parameter int DIV_WIDTH  = DIV_W,
  parameter int HOLD_WIDTH = HOLD_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [FREQ_WIDTH-1:0] cfg_min,
  input  logic [FREQ_WIDTH-1:0] cfg_max,
  input  logic [FREQ_WIDTH-1:0] cfg_step,
  input  logic [DIV_WIDTH-1:0]  cfg_div,
  input  logic [1:0]            cfg_mode,
  input  logic [HOLD_WIDTH-1:0] cfg_hold,
  input  logic                  start,
  input  logic                  stop,
  output logic                  nco_en,
  output logic [FREQ_WIDTH-1:0] nco_freq,
  output logic                  busy,
  output logic                  done,
  output logic                  tick,
  output logic                  cfg_err
);
  sweep_cfg_t cfg;
  sweep_state_e state, state_d;
  logic [FREQ_WIDTH-1:0] freq_d, stp, up_nxt, dn_nxt;
  logic [FREQ_WIDTH:0] up_sum, dn_lim;
  logic [HOLD_WIDTH-1:0] dwell, dwell_d;
  logic wrap, clr, done_d, go;
  assign busy = state != S_IDLE;
  assign nco_en = busy;
  assign cfg_ready = !busy;
  assign tick = wrap && busy;
  tick_div #(.WIDTH(DIV_WIDTH)) u_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .div  (cfg.div),
    .wrap (wrap)
  );
  always_comb begin
    state_d = state;
    freq_d = nco_freq;
    dwell_d = dwell;
    done_d = 1'b0;
    go = !busy && start && !stop && !cfg_err;
    clr = go;
    stp = (cfg.step == '0) ? FREQ_WIDTH'(1) : cfg.step;
    up_sum = {1'b0, nco_freq} + {1'b0, stp};
    dn_lim = {1'b0, cfg.min} + {1'b0, stp};
    up_nxt = (up_sum > {1'b0, cfg.max}) ? cfg.max : up_sum[FREQ_WIDTH-1:0];
    dn_nxt = ({1'b0, nco_freq} < dn_lim) ? cfg.min : nco_freq - stp;
    if (go) begin
      state_d = (cfg.mode == DOWN_ONCE) ? S_DOWN : S_UP;
      freq_d = (cfg.mode == DOWN_ONCE) ? cfg.max : cfg.min;
    end else if (busy && stop) begin
      state_d = S_IDLE;
    end else if (tick) begin
      case (state)
        S_UP: begin
          if (nco_freq != cfg.max) freq_d = up_nxt;
          else if (cfg.mode == TRIANGLE) begin
            state_d = S_HOLD_TOP;
            dwell_d = '0;
          end else if (cfg.mode == SAW) freq_d = cfg.min;
          else begin
            state_d = S_IDLE;
            done_d = 1'b1;
          end
        end
        S_DOWN: begin
          if (nco_freq != cfg.min) freq_d = dn_nxt;
          else if (cfg.mode == TRIANGLE) begin
            state_d = S_HOLD_BOT;
            dwell_d = '0;
          end else begin
            state_d = S_IDLE;
            done_d = 1'b1;
          end
        end
        // leaving a dwell takes the first step; a zero-width range skips straight to the other dwell
        S_HOLD_TOP: begin
          dwell_d = (dwell == cfg.hold) ? '0 : dwell + 1'b1;
          if (dwell == cfg.hold) begin
            state_d = (nco_freq == cfg.min) ? S_HOLD_BOT : S_DOWN;
            freq_d = dn_nxt;
          end
        end
        S_HOLD_BOT: begin
          dwell_d = (dwell == cfg.hold) ? '0 : dwell + 1'b1;
          if (dwell == cfg.hold) begin
            state_d = (nco_freq == cfg.max) ? S_HOLD_TOP : S_UP;
            freq_d = up_nxt;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      nco_freq <= '0;
      dwell <= '0;
      done <= 1'b0;
      cfg_err <= 1'b0;
      cfg <= CFG_DEFAULT;
    end else begin
      state <= state_d;
      nco_freq <= freq_d;
      dwell <= dwell_d;
      done <= done_d;
      if (cfg_valid && cfg_ready) begin
        cfg <= '{min: cfg_min, max: cfg_max, step: cfg_step, div: cfg_div, mode: sweep_mode_e'(cfg_mode), hold: cfg_hold};
        cfg_err <= cfg_min > cfg_max;
      end
    end
  end
endmodule
